// File: rtl/elastic_pipe_reg_pkg.sv
// Shared core constants for the pipelined datapath.
// XLEN is the default payload width of a stage boundary.
package elastic_pipe_reg_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/elastic_pipe_reg_skid_stage.sv
// One valid/ready stage built as a two-entry skid buffer.
// The main register faces downstream; the skid register absorbs a single beat of backpressure.
module skid_stage
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);
    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             up_fire;

    // Ready depends only on the skid register, so backpressure is fully registered.
    assign up_ready = !skid_valid;
    assign up_fire  = up_valid && !skid_valid;
    assign dn_valid = main_valid;
    assign dn_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RESET_VALUE;
            skid_data  <= RESET_VALUE;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (dn_ready || !main_valid) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (up_fire) begin
                main_data  <= up_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (up_fire) begin
            // Main is held by downstream: park the incoming beat.
            skid_data  <= up_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH chained skid stages with flush and an occupancy count.
// Serves as the stage boundary between the core's pipeline stages.
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    logic [DEPTH:0]   valid_chain;
    logic [DEPTH:0]   ready_chain;
    logic [WIDTH-1:0] data_chain [DEPTH+1];
    logic             in_fire;
    logic             out_fire;

    assign valid_chain[0]     = in_valid;
    assign data_chain[0]      = in_data;
    assign ready_chain[DEPTH] = out_ready;

    // Stage k's main register drives stage k+1's upstream side.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        skid_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (valid_chain[k]),
            .up_ready (ready_chain[k]),
            .up_data  (data_chain[k]),
            .dn_valid (valid_chain[k+1]),
            .dn_ready (ready_chain[k+1]),
            .dn_data  (data_chain[k+1])
        );
    end

    // Flush blocks both handshakes so that nothing is transferred while entries are discarded.
    assign in_ready  = ready_chain[0] && !flush && !rst;
    assign out_valid = valid_chain[DEPTH] && !flush;
    assign out_data  = data_chain[DEPTH];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + 1'b1;
        end else if (!in_fire && out_fire) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg (DEPTH=3, WIDTH=8, RESET_VALUE=0x5A): directed vectors
// plus a FIFO scoreboard monitor that checks every emitted beat and the occupancy count.
module tb_elastic_pipe_reg;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'h5A;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q [$];
    logic [7:0] out_log [$];
    logic       fire;
    int         idx;

    elastic_pipe_reg #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted beats are queued, emitted beats must match the queue head.
    always @(negedge clk) begin
        check("count_vs_model", 32'(count), 32'(model_q.size()));
        if (rst) begin
            model_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_log.push_back(out_data);
                if (model_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else begin
                    check("out_data_order", 32'(out_data), 32'(model_q.pop_front()));
                end
            end
            if (in_valid && in_ready) model_q.push_back(in_data);
            if (flush) model_q.delete();
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with an upstream offer present
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready), 0);
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_count", 32'(count), 0);
            check("rst_out_data", 32'(out_data), 32'(RV));
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_count", 32'(count), 0);
        check("post_rst_out_data", 32'(out_data), 32'(RV));
        @(posedge clk); #1;

        // Streaming 0x01..0x10: item i appears three cycles after it is offered
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 1);
            if (i <= 3) begin
                check("stream_fill_valid", 32'(out_valid), 0);
                check("stream_fill_count", 32'(count), i - 1);
            end else begin
                check("stream_out_valid", 32'(out_valid), 1);
                check("stream_out_data", 32'(out_data), i - 3);
                check("stream_count", 32'(count), 3);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("stream_drain_valid", 32'(out_valid), 1);
            check("stream_drain_data", 32'(out_data), 14 + j);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stream_empty_valid", 32'(out_valid), 0);
        check("stream_empty_count", 32'(count), 0);
        @(posedge clk); #1;

        // Backpressure: offer 0xA0..0xA7 with out_ready low
        out_ready = 1'b0; out_log.delete(); idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 8); in_data = 8'hA0 + 8'(idx);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        check("bp_accepted", 32'(idx), 2 * DEPTH);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_count", 32'(count), 2 * DEPTH);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_out_head", 32'(out_data), 32'hA0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (idx < 8 || count != 0); c++) begin
            in_valid = (idx < 8); in_data = 8'hA0 + 8'(idx);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drained_count", 32'(count), 0);
        check("bp_log_size", 32'(out_log.size()), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < out_log.size()) check("bp_log_item", 32'(out_log[k]), 32'hA0 + k);
        end
        @(posedge clk); #1;

        // Random stalls on both sides
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && count != 0; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rand_drain_count", 32'(count), 0);
        @(posedge clk); #1;

        // Flush with four entries held and an offer pending
        out_ready = 1'b0; out_log.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("fl_count_before", 32'(count), 4);
        check("fl_out_valid", 32'(out_valid), 0);
        check("fl_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_count_after", 32'(count), 0);
        check("fl_out_valid_after", 32'(out_valid), 0);
        check("fl_in_ready_after", 32'(in_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        check("fl_nothing_emitted", 32'(out_log.size()), 0);

        // Reset while three entries are held and traffic is active
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 8'hCC; out_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("mr_count_before", 32'(count), 3);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_log.delete();
        @(negedge clk);
        check("mr_count", 32'(count), 0);
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_out_data", 32'(out_data), 32'(RV));
        check("mr_in_ready", 32'(in_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        check("mr_nothing_emitted", 32'(out_log.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
